alu_share_arbiter: RTL

//  Shares one combinational yAlu between two requesters (e.g. EX-stage and branch/address unit).

---
 rtl/alu_share_arbiter_pkg.sv | 18 +
 rtl/alu_share_arbiter_rr_arb2.sv | 14 +
 rtl/alu_share_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared encodings for the ALU sharing arbiter: yAlu op codes and FSM states.
package alu_share_arbiter_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [OP_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin picker: when both requesters are valid, prio selects the winner.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = valid[0] & (~valid[1] | ~prio);
    gnt[1] = valid[1] & (~valid[0] |  prio);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational yAlu between two requesters with round-robin
// arbitration, registered operands, a held result and saturating grant counters.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [W-1:0]     alu_z,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_z,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  state_t     state;
  logic       prio;
  logic       op_id;
  logic [1:0] arb_gnt;
  logic [1:0] gnt;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .prio  (prio),
    .gnt   (arb_gnt)
  );

  // Ready is the combinational grant, only offered while idle.
  always_comb begin
    gnt        = 2'b00;
    if (state == S_IDLE) gnt = arb_gnt;
    req0_ready = gnt[0];
    req1_ready = gnt[1];
  end

  // The operand registers drive the yAlu directly, so alu_* only move on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      prio      <= 1'b0;
      op_id     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_z     <= '0;
      rsp_zero  <= 1'b0;
      gnt_cnt0  <= '0;
      gnt_cnt1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt != 2'b00) begin
            alu_a  <= gnt[1] ? req1_a  : req0_a;
            alu_b  <= gnt[1] ? req1_b  : req0_b;
            alu_op <= gnt[1] ? req1_op : req0_op;
            op_id  <= gnt[1];
            prio   <= ~gnt[1];
            if (gnt[0] && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (gnt[1] && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_z     <= alu_z;
          rsp_zero  <= alu_zero;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
